// File: rtl/ooo_pkg.sv
// ---------------------------------------------------------------------------
// ooo_pkg
// Shared constants and types for the out-of-order core back end.
//   ROB_DEPTH / TAG_W / DATA_W : reorder buffer geometry and datapath width
//   FWD_*                       : bit positions inside a forwarding bus word
//   rob_entry_t                 : layout of one reorder buffer entry
//   OP_HALT                     : opcode value decode uses to flag a halt
//   popcount4                   : number of set bits in a 4-bit request mask
// ---------------------------------------------------------------------------
package ooo_pkg;

  localparam int ROB_DEPTH   = 64;
  localparam int TAG_W       = 6;
  localparam int DATA_W      = 16;
  localparam int DST_W       = 3;
  localparam int ALLOC_SLOTS = 4;

  // Forwarding bus word: {valid, tag, value}
  localparam int FWD_W      = 1 + TAG_W + DATA_W;
  localparam int FWD_VALID  = 22;
  localparam int FWD_TAG_HI = 21;
  localparam int FWD_TAG_LO = 16;
  localparam int FWD_VAL_HI = 15;
  localparam int FWD_VAL_LO = 0;

  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic              wr;
    logic [DST_W-1:0]  dst;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] pc;
    logic              halt;
  } rob_entry_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// ---------------------------------------------------------------------------
// rob_commit_select
// Purely combinational two-slot retire selection for the reorder buffer.
//   i_block            : suppresses all commits (flush or halted)
//   i_*0 / i_*1        : fields of the head entry and the entry after it
//   o_commit0/1        : slot commits this cycle
//   o_wen/waddr/wdata  : register file write ports
//   o_retireCount      : number of entries leaving the buffer (0..2)
//   o_retireHalt       : a halt entry is among the committed ones
// ---------------------------------------------------------------------------
module rob_commit_select
  import ooo_pkg::*;
(
  input  logic              i_block,
  input  logic              i_valid0,
  input  logic              i_ready0,
  input  logic              i_wr0,
  input  logic              i_halt0,
  input  logic [DST_W-1:0]  i_dst0,
  input  logic [DATA_W-1:0] i_value0,
  input  logic              i_valid1,
  input  logic              i_ready1,
  input  logic              i_wr1,
  input  logic              i_halt1,
  input  logic [DST_W-1:0]  i_dst1,
  input  logic [DATA_W-1:0] i_value1,
  output logic              o_commit0,
  output logic              o_commit1,
  output logic              o_wen0,
  output logic              o_wen1,
  output logic [DST_W-1:0]  o_waddr0,
  output logic [DST_W-1:0]  o_waddr1,
  output logic [DATA_W-1:0] o_wdata0,
  output logic [DATA_W-1:0] o_wdata1,
  output logic [1:0]        o_retireCount,
  output logic              o_retireHalt
);

  // Slot1 may only follow a committing, non-halt slot0 so a halt is always
  // the youngest thing retired. When both slots write the same register the
  // older write is dropped since the younger one would overwrite it anyway.
  always_comb begin
    o_commit0     = !i_block && i_valid0 && i_ready0;
    o_commit1     = o_commit0 && !i_halt0 && i_valid1 && i_ready1;
    o_wen1        = o_commit1 && i_wr1;
    o_wen0        = o_commit0 && i_wr0 && !(o_wen1 && (i_dst1 == i_dst0));
    o_waddr0      = o_commit0 ? i_dst0   : '0;
    o_wdata0      = o_commit0 ? i_value0 : '0;
    o_waddr1      = o_commit1 ? i_dst1   : '0;
    o_wdata1      = o_commit1 ? i_value1 : '0;
    o_retireCount = 2'(o_commit0) + 2'(o_commit1);
    o_retireHalt  = (o_commit0 && i_halt0) || (o_commit1 && i_halt1);
  end

endmodule

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// 64-entry circular reorder buffer between dispatch and the register file.
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : drop every entry at the next edge
//   alloc_*               : up to 4 in-order allocations per cycle
//   alloc_accept/alloc_tag: all-or-nothing grant and the tags handed out
//   free_count            : unused entries (0..64)
//   fwd_a..fwd_d          : result buses {valid, tag, value}, d has priority
//   q_tag*/q_ready*/q_value*: operand lookup by tag for dispatch
//   wen*/waddr*/wdata*    : two register file write ports
//   retire_count/retire_halt/halted : retire status and sticky halt
// ---------------------------------------------------------------------------
module reorder_buffer
  import ooo_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [ALLOC_SLOTS-1:0]        alloc_en,
  input  logic [ALLOC_SLOTS-1:0]        alloc_wr,
  input  logic [ALLOC_SLOTS*DST_W-1:0]  alloc_dst,
  input  logic [ALLOC_SLOTS*DATA_W-1:0] alloc_pc,
  input  logic [ALLOC_SLOTS-1:0]        alloc_halt,
  output logic                          alloc_accept,
  output logic [ALLOC_SLOTS*TAG_W-1:0]  alloc_tag,
  output logic [TAG_W:0]                free_count,
  input  logic [FWD_W-1:0]              fwd_a,
  input  logic [FWD_W-1:0]              fwd_b,
  input  logic [FWD_W-1:0]              fwd_c,
  input  logic [FWD_W-1:0]              fwd_d,
  input  logic [TAG_W-1:0]              q_tag0,
  input  logic [TAG_W-1:0]              q_tag1,
  output logic                          q_ready0,
  output logic                          q_ready1,
  output logic [DATA_W-1:0]             q_value0,
  output logic [DATA_W-1:0]             q_value1,
  output logic                          wen0,
  output logic                          wen1,
  output logic [DST_W-1:0]              waddr0,
  output logic [DST_W-1:0]              waddr1,
  output logic [DATA_W-1:0]             wdata0,
  output logic [DATA_W-1:0]             wdata1,
  output logic [1:0]                    retire_count,
  output logic                          retire_halt,
  output logic                          halted
);

  rob_entry_t       r_rob [ROB_DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;
  logic             r_halted;

  logic [2:0]       w_allocN;
  logic [TAG_W:0]   w_acceptN;
  logic             w_accept;
  logic [TAG_W-1:0] w_head1;
  logic             w_commit0;
  logic             w_commit1;
  logic [1:0]       w_retireCount;
  logic             w_retireHalt;
  logic [FWD_W-1:0] w_fwd [4];

  assign w_fwd[0] = fwd_a;
  assign w_fwd[1] = fwd_b;
  assign w_fwd[2] = fwd_c;
  assign w_fwd[3] = fwd_d;

  // Fullness comes from the occupancy counter; head==tail is ambiguous
  // because it holds both when empty and when all 64 entries are live.
  assign w_allocN   = popcount4(alloc_en);
  assign free_count = (TAG_W+1)'(ROB_DEPTH) - r_count;
  assign w_accept   = (w_allocN != 3'd0) && ((TAG_W+1)'(w_allocN) <= free_count)
                      && !flush && !r_halted;
  assign w_acceptN  = w_accept ? (TAG_W+1)'(w_allocN) : '0;
  assign alloc_accept = w_accept;

  // Tags are offered every cycle whether or not the request is granted, so
  // dispatch can rename in parallel with the accept decision.
  always_comb begin
    alloc_tag = '0;
    for (int i = 0; i < ALLOC_SLOTS; i++) begin
      alloc_tag[i*TAG_W +: TAG_W] = r_tail + TAG_W'(i);
    end
  end

  // Lookups see registered state only; an entry that is not live reads as
  // not-ready with a zero value.
  always_comb begin
    q_ready0 = r_rob[q_tag0].valid && r_rob[q_tag0].ready;
    q_value0 = r_rob[q_tag0].valid ? r_rob[q_tag0].value : '0;
    q_ready1 = r_rob[q_tag1].valid && r_rob[q_tag1].ready;
    q_value1 = r_rob[q_tag1].valid ? r_rob[q_tag1].value : '0;
  end

  assign w_head1 = r_head + TAG_W'(1);

  rob_commit_select u_commitSelect (
    .i_block       (flush || r_halted),
    .i_valid0      (r_rob[r_head].valid),
    .i_ready0      (r_rob[r_head].ready),
    .i_wr0         (r_rob[r_head].wr),
    .i_halt0       (r_rob[r_head].halt),
    .i_dst0        (r_rob[r_head].dst),
    .i_value0      (r_rob[r_head].value),
    .i_valid1      (r_rob[w_head1].valid),
    .i_ready1      (r_rob[w_head1].ready),
    .i_wr1         (r_rob[w_head1].wr),
    .i_halt1       (r_rob[w_head1].halt),
    .i_dst1        (r_rob[w_head1].dst),
    .i_value1      (r_rob[w_head1].value),
    .o_commit0     (w_commit0),
    .o_commit1     (w_commit1),
    .o_wen0        (wen0),
    .o_wen1        (wen1),
    .o_waddr0      (waddr0),
    .o_waddr1      (waddr1),
    .o_wdata0      (wdata0),
    .o_wdata1      (wdata1),
    .o_retireCount (w_retireCount),
    .o_retireHalt  (w_retireHalt)
  );

  assign retire_count = w_retireCount;
  assign retire_halt  = w_retireHalt;
  assign halted       = r_halted;

  // Entry array and pointers. Forwarding is applied bus by bus so a later
  // bus overrides an earlier one on a duplicate tag. Commit clears come
  // next; new allocations only ever land on entries that were not live, so
  // they cannot collide with either of the above.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_fwd[b][FWD_VALID] && r_rob[w_fwd[b][FWD_TAG_HI:FWD_TAG_LO]].valid) begin
          r_rob[w_fwd[b][FWD_TAG_HI:FWD_TAG_LO]].ready <= 1'b1;
          r_rob[w_fwd[b][FWD_TAG_HI:FWD_TAG_LO]].value <= w_fwd[b][FWD_VAL_HI:FWD_VAL_LO];
        end
      end
      if (w_commit0) begin
        r_rob[r_head] <= '0;
      end
      if (w_commit1) begin
        r_rob[w_head1] <= '0;
      end
      if (w_accept) begin
        for (int i = 0; i < ALLOC_SLOTS; i++) begin
          if (3'(i) < w_allocN) begin
            r_rob[r_tail + TAG_W'(i)].valid <= 1'b1;
            r_rob[r_tail + TAG_W'(i)].ready <= 1'b0;
            r_rob[r_tail + TAG_W'(i)].wr    <= alloc_wr[i];
            r_rob[r_tail + TAG_W'(i)].dst   <= alloc_dst[i*DST_W +: DST_W];
            r_rob[r_tail + TAG_W'(i)].value <= '0;
            r_rob[r_tail + TAG_W'(i)].pc    <= alloc_pc[i*DATA_W +: DATA_W];
            r_rob[r_tail + TAG_W'(i)].halt  <= alloc_halt[i];
          end
        end
      end
      r_head  <= r_head + TAG_W'(w_retireCount);
      r_tail  <= r_tail + w_acceptN[TAG_W-1:0];
      r_count <= r_count + w_acceptN - (TAG_W+1)'(w_retireCount);
    end
  end

  // Sticky halt survives flushes; only reset brings the machine back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halted <= 1'b0;
    end else if (w_retireHalt) begin
      r_halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
// Directed bench for reorder_buffer. Expected retire-port activity is queued
// when results are forwarded and compared when the commit cycle arrives.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;
  import ooo_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [3:0]  alloc_en, alloc_wr, alloc_halt;
  logic [11:0] alloc_dst;
  logic [63:0] alloc_pc;
  logic        alloc_accept;
  logic [23:0] alloc_tag;
  logic [6:0]  free_count;
  logic [22:0] fwd_a, fwd_b, fwd_c, fwd_d;
  logic [5:0]  q_tag0, q_tag1;
  logic        q_ready0, q_ready1;
  logic [15:0] q_value0, q_value1;
  logic        wen0, wen1;
  logic [2:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  retire_count;
  logic        retire_halt, halted;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wen0;
    logic [2:0]  waddr0;
    logic [15:0] wdata0;
    logic        wen1;
    logic [2:0]  waddr1;
    logic [15:0] wdata1;
    logic [1:0]  cnt;
    logic        halt;
  } retire_t;

  retire_t expQ[$];

  reorder_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_en(alloc_en), .alloc_wr(alloc_wr), .alloc_dst(alloc_dst),
    .alloc_pc(alloc_pc), .alloc_halt(alloc_halt),
    .alloc_accept(alloc_accept), .alloc_tag(alloc_tag), .free_count(free_count),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .fwd_d(fwd_d),
    .q_tag0(q_tag0), .q_tag1(q_tag1),
    .q_ready0(q_ready0), .q_ready1(q_ready1),
    .q_value0(q_value0), .q_value1(q_value1),
    .wen0(wen0), .wen1(wen1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .retire_count(retire_count), .retire_halt(retire_halt), .halted(halted)
  );

  always #5 clk = ~clk;

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushRetire(input logic e0, input logic [2:0] a0, input logic [15:0] d0,
                            input logic e1, input logic [2:0] a1, input logic [15:0] d1,
                            input logic [1:0] c, input logic h);
    retire_t r;
    r.wen0 = e0; r.waddr0 = a0; r.wdata0 = d0;
    r.wen1 = e1; r.waddr1 = a1; r.wdata1 = d1;
    r.cnt  = c;  r.halt   = h;
    expQ.push_back(r);
  endtask

  // Address/data are only meaningful on an enabled write port.
  task automatic checkRetire(input string tag);
    retire_t r;
    total++;
    assert (expQ.size() != 0) else begin
      bad++;
      $error("[TB] FAIL %s observed=empty-queue expected=entry", tag);
    end
    if (expQ.size() != 0) begin
      r = expQ.pop_front();
      checkOutput({tag, ".wen0"}, 32'(wen0), 32'(r.wen0));
      checkOutput({tag, ".wen1"}, 32'(wen1), 32'(r.wen1));
      checkOutput({tag, ".count"}, 32'(retire_count), 32'(r.cnt));
      checkOutput({tag, ".halt"}, 32'(retire_halt), 32'(r.halt));
      if (r.wen0) begin
        checkOutput({tag, ".waddr0"}, 32'(waddr0), 32'(r.waddr0));
        checkOutput({tag, ".wdata0"}, 32'(wdata0), 32'(r.wdata0));
      end
      if (r.wen1) begin
        checkOutput({tag, ".waddr1"}, 32'(waddr1), 32'(r.waddr1));
        checkOutput({tag, ".wdata1"}, 32'(wdata1), 32'(r.wdata1));
      end
    end
  endtask

  task automatic clearInputs();
    flush = 0; alloc_en = 0; alloc_wr = 0; alloc_dst = 0; alloc_pc = 0; alloc_halt = 0;
    fwd_a = 0; fwd_b = 0; fwd_c = 0; fwd_d = 0; q_tag0 = 0; q_tag1 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic [3:0] wr,
                               input logic [11:0] dst, input logic [3:0] hlt);
    alloc_en = en; alloc_wr = wr; alloc_dst = dst; alloc_halt = hlt;
    alloc_pc = 64'h0103_0102_0101_0100;
  endtask

  task automatic driveFwd(input int bus, input logic [5:0] tag, input logic [15:0] val);
    case (bus)
      0: fwd_a = {1'b1, tag, val};
      1: fwd_b = {1'b1, tag, val};
      2: fwd_c = {1'b1, tag, val};
      default: fwd_d = {1'b1, tag, val};
    endcase
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    logic [11:0] dsts;
    clearInputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;

    // reset state
    checkOutput("rst.free", 32'(free_count), 32'd64);
    checkOutput("rst.tags", 32'(alloc_tag), 32'h000C2040);
    checkOutput("rst.accept", 32'(alloc_accept), 32'd0);
    checkOutput("rst.retire", 32'(retire_count), 32'd0);
    checkOutput("rst.halted", 32'(halted), 32'd0);
    checkOutput("rst.wen0", 32'(wen0), 32'd0);
    checkOutput("rst.qready", 32'(q_ready0), 32'd0);

    // single allocation burst and first commit
    applyStimulus(4'hF, 4'hF, {3'd4, 3'd3, 3'd2, 3'd1}, 4'h0);
    #1;
    checkOutput("t1.accept", 32'(alloc_accept), 32'd1);
    checkOutput("t1.tags", 32'(alloc_tag), 32'h000C2040);
    tick(); clearInputs(); #1;
    checkOutput("t1.free", 32'(free_count), 32'd60);
    checkOutput("t1.notYet", 32'(wen0), 32'd0);
    driveFwd(0, 6'd0, 16'h0005);
    pushRetire(1, 3'd1, 16'h0005, 0, 3'd0, 16'h0, 2'd1, 0);
    tick(); clearInputs(); q_tag0 = 6'd0; q_tag1 = 6'd1; #1;
    checkOutput("t1.qready0", 32'(q_ready0), 32'd1);
    checkOutput("t1.qvalue0", 32'(q_value0), 32'h5);
    checkOutput("t1.qready1", 32'(q_ready1), 32'd0);
    checkRetire("t1.retire");
    tick();

    // same destination in both slots: younger write wins
    doReset();
    applyStimulus(4'h3, 4'h3, {3'd0, 3'd0, 3'd2, 3'd2}, 4'h0);
    tick(); clearInputs();
    driveFwd(0, 6'd0, 16'h0011);
    driveFwd(1, 6'd1, 16'h0022);
    pushRetire(0, 3'd0, 16'h0, 1, 3'd2, 16'h0022, 2'd2, 0);
    tick(); clearInputs(); #1;
    checkRetire("t2.sameDst");
    tick(); #1;
    checkOutput("t2.free", 32'(free_count), 32'd64);

    // fill to capacity, then wrap
    doReset();
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) dsts[i*3 +: 3] = 3'(((4*k + i) % 7) + 1);
      applyStimulus(4'hF, 4'hF, dsts, 4'h0);
      #1;
      checkOutput("t3.fillAccept", 32'(alloc_accept), 32'd1);
      tick(); clearInputs();
    end
    #1;
    checkOutput("t3.full", 32'(free_count), 32'd0);
    applyStimulus(4'h1, 4'h1, 12'h001, 4'h0);
    #1;
    checkOutput("t3.rejectFull", 32'(alloc_accept), 32'd0);
    clearInputs();
    driveFwd(0, 6'd0, 16'h00A0);
    driveFwd(1, 6'd1, 16'h00A1);
    pushRetire(1, 3'd1, 16'h00A0, 1, 3'd2, 16'h00A1, 2'd2, 0);
    tick(); clearInputs(); #1;
    checkRetire("t3.retire2");
    tick(); #1;
    checkOutput("t3.free2", 32'(free_count), 32'd2);
    applyStimulus(4'h3, 4'h3, 12'h009, 4'h0);
    #1;
    checkOutput("t3.wrapAccept", 32'(alloc_accept), 32'd1);
    checkOutput("t3.wrapTags", 32'(alloc_tag[11:0]), 32'h040);
    tick(); clearInputs(); #1;
    checkOutput("t3.fullAgain", 32'(free_count), 32'd0);

    // out-of-order completion
    doReset();
    applyStimulus(4'h7, 4'h7, {3'd0, 3'd3, 3'd2, 3'd1}, 4'h0);
    tick(); clearInputs();
    driveFwd(0, 6'd2, 16'h0033);
    pushRetire(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 2'd0, 0);
    tick(); clearInputs(); #1;
    checkRetire("t4.none");
    driveFwd(0, 6'd0, 16'h0010);
    pushRetire(1, 3'd1, 16'h0010, 0, 3'd0, 16'h0, 2'd1, 0);
    tick(); clearInputs(); #1;
    checkRetire("t4.first");
    driveFwd(0, 6'd1, 16'h0020);
    pushRetire(1, 3'd2, 16'h0020, 1, 3'd3, 16'h0033, 2'd2, 0);
    tick(); clearInputs(); #1;
    checkRetire("t4.pair");
    tick();

    // halt stops retirement and allocation
    doReset();
    applyStimulus(4'h7, 4'h5, {3'd0, 3'd3, 3'd0, 3'd1}, 4'h2);
    tick(); clearInputs();
    driveFwd(0, 6'd0, 16'h0001);
    driveFwd(1, 6'd1, 16'h0000);
    driveFwd(2, 6'd2, 16'h0003);
    pushRetire(1, 3'd1, 16'h0001, 0, 3'd0, 16'h0, 2'd2, 1);
    tick(); clearInputs(); #1;
    checkRetire("t5.halt");
    checkOutput("t5.notHaltedYet", 32'(halted), 32'd0);
    tick(); clearInputs();
    applyStimulus(4'h1, 4'h1, 12'h001, 4'h0);
    #1;
    checkOutput("t5.halted", 32'(halted), 32'd1);
    checkOutput("t5.noAccept", 32'(alloc_accept), 32'd0);
    checkOutput("t5.noRetire", 32'(retire_count), 32'd0);
    checkOutput("t5.noHaltPulse", 32'(retire_halt), 32'd0);
    tick(); clearInputs(); #1;
    checkOutput("t5.thirdStuck", 32'(retire_count), 32'd0);
    checkOutput("t5.stillHalted", 32'(halted), 32'd1);

    // flush with live entries
    doReset();
    applyStimulus(4'hF, 4'hF, {3'd4, 3'd3, 3'd2, 3'd1}, 4'h0);
    tick(); clearInputs();
    applyStimulus(4'hF, 4'hF, {3'd4, 3'd3, 3'd2, 3'd1}, 4'h0);
    tick(); clearInputs();
    applyStimulus(4'h3, 4'h3, {3'd0, 3'd0, 3'd6, 3'd5}, 4'h0);
    driveFwd(0, 6'd0, 16'h0077);
    tick(); clearInputs(); #1;
    checkOutput("t6.live", 32'(free_count), 32'd54);
    checkOutput("t6.wouldCommit", 32'(wen0), 32'd1);
    flush = 1;
    applyStimulus(4'hF, 4'hF, 12'h249, 4'h0);
    driveFwd(0, 6'd3, 16'h0055);
    #1;
    checkOutput("t6.accept", 32'(alloc_accept), 32'd0);
    checkOutput("t6.wen0", 32'(wen0), 32'd0);
    checkOutput("t6.wen1", 32'(wen1), 32'd0);
    checkOutput("t6.retire", 32'(retire_count), 32'd0);
    tick(); clearInputs(); q_tag0 = 6'd3; #1;
    checkOutput("t6.free", 32'(free_count), 32'd64);
    checkOutput("t6.qready", 32'(q_ready0), 32'd0);
    checkOutput("t6.qvalue", 32'(q_value0), 32'd0);
    checkOutput("t6.tags", 32'(alloc_tag), 32'h000C2040);

    checkOutput("end.queueEmpty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
